logic_op_arbiter: RTL

//  Shares one bitwise logic-op unit between NREQ requesters.

---
 rtl/logic_op_pkg.sv | 23 ++
 rtl/logic_op_unit.sv | 32 +++
 rtl/logic_op_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/logic_op_pkg.sv
// Shared opcode and FSM state types for the logic-op arbiter and its datapath.
package logic_op_pkg;

    typedef enum logic [2:0] {
        OP_AND      = 3'd0,
        OP_OR       = 3'd1,
        OP_NOT      = 3'd2,
        OP_NAND     = 3'd3,
        OP_NOR      = 3'd4,
        OP_XOR      = 3'd5,
        OP_XNOR     = 3'd6,
        OP_RESERVED = 3'd7
    } op_e;

    localparam logic [2:0] OP_RSVD = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/logic_op_unit.sv
// Combinational bitwise logic-op datapath: {err, data} = f(op, a, b).
module logic_op_unit
    import logic_op_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] data,
    output logic         err
);

    always_comb begin
        data = '0;
        err  = 1'b0;
        case (op_e'(op))
            OP_AND:  data = a & b;
            OP_OR:   data = a | b;
            OP_NOT:  data = ~a;
            OP_NAND: data = ~(a & b);
            OP_NOR:  data = ~(a | b);
            OP_XOR:  data = a ^ b;
            OP_XNOR: data = ~(a ^ b);
            default: begin
                data = '0;
                err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one logic-op unit between NREQ requesters.
// Optional LOGIC_ARB_PARITY_EN adds an even-parity output registered with rsp_data.
module logic_op_arbiter
    import logic_op_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*3-1:0] req_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_data,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_err
`ifdef LOGIC_ARB_PARITY_EN
    ,
    output logic              rsp_par
`endif
);

    state_e         state;
    state_e         state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] winner;
    logic           found;
    logic           accept;
    int             idx;

    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [2:0]     op_q;
    logic [IDW-1:0] id_q;

    logic [W-1:0]   unit_data;
    logic           unit_err;

    // Walk downward so the valid requester nearest rr_ptr is the last assignment.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_valid[idx[IDW-1:0]]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    assign accept = (state == IDLE) && found;

    always_comb begin
        req_ready = '0;
        if (rst_n && accept) req_ready[winner] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            id_q   <= '0;
        end else if (accept) begin
            rr_ptr <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
            a_q    <= req_a[int'(winner)*W +: W];
            b_q    <= req_b[int'(winner)*W +: W];
            op_q   <= req_op[int'(winner)*3 +: 3];
            id_q   <= winner;
        end
    end

    logic_op_unit #(.W(W)) u_unit (
        .op   (op_q),
        .a    (a_q),
        .b    (b_q),
        .data (unit_data),
        .err  (unit_err)
    );

    // Result registers load only in EXEC, so they hold through RESP backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_id   <= '0;
            rsp_err  <= 1'b0;
        end else if (state == EXEC) begin
            rsp_data <= unit_data;
            rsp_id   <= id_q;
            rsp_err  <= unit_err;
        end
    end

`ifdef LOGIC_ARB_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              rsp_par <= 1'b0;
        else if (state == EXEC)  rsp_par <= ^unit_data;
    end
`endif

endmodule
